// File: rtl/keypad_cmd_decoder.sv
// Keypad front end for the 2048 core: synchronise, debounce and qualify one key press into one
// move/new-game command on a valid/ready handshake. Define KEYPAD_AUTOREPEAT_EN for held-key repeat.
module keypad_cmd_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned RELEASE_CYCLES  = 4,
    parameter int unsigned REPEAT_CYCLES   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] keypadPressed,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic        cmd_dropped,
    output logic        key_busy
);

    typedef enum logic [1:0] {StIdle, StDebounce, StHeld, StRelease} state_e;

    localparam logic [15:0] DebTarget = DEBOUNCE_CYCLES[15:0];
    localparam logic [15:0] RelTarget = RELEASE_CYCLES[15:0];

    logic [11:0] sync1_q, sync2_q;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [11:0] pat_q, pat_d;
    logic        key_valid, key_zero, same_pat;
    logic [2:0]  key_code;
    logic        emit;
    logic        cmd_valid_q, cmd_valid_d;
    logic [2:0]  cmd_code_q, cmd_code_d;
    logic        dropped_q, dropped_d;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [15:0] RepTarget = REPEAT_CYCLES[15:0];
    logic [15:0] rep_q, rep_d;
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keypadPressed;
            sync2_q <= sync1_q;
        end
    end

    // Case-equality keeps X/Z on the key lines decoding as "no key".
    always_comb begin
        key_valid = 1'b1;
        key_code  = 3'd0;
        if (sync2_q === 12'h002) begin
            key_code = 3'd0;
        end else if (sync2_q === 12'h080) begin
            key_code = 3'd1;
        end else if (sync2_q === 12'h008) begin
            key_code = 3'd2;
        end else if (sync2_q === 12'h020) begin
            key_code = 3'd3;
        end else if (sync2_q === 12'h200) begin
            key_code = 3'd4;
        end else begin
            key_valid = 1'b0;
        end
    end

    assign key_zero = (sync2_q === 12'h000);
    assign same_pat = key_valid && (sync2_q === pat_q);
    assign cnt_inc  = cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        emit    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (key_valid) begin
                    pat_d = sync2_q;
                    cnt_d = 16'd1;
                    if (DebTarget <= 16'd1) begin
                        emit    = 1'b1;
                        state_d = StHeld;
                    end else begin
                        state_d = StDebounce;
                    end
                end
            end
            StDebounce: begin
                if (same_pat) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= DebTarget) begin
                        emit    = 1'b1;
                        state_d = StHeld;
                    end
                end else begin
                    cnt_d   = 16'd0;
                    state_d = StIdle;
                end
            end
            StHeld: begin
`ifdef KEYPAD_AUTOREPEAT_EN
                if (same_pat) begin
                    if (rep_q + 16'd1 >= RepTarget) begin
                        emit  = 1'b1;
                        rep_d = 16'd0;
                    end else begin
                        rep_d = rep_q + 16'd1;
                    end
                end else begin
                    rep_d = 16'd0;
                end
`endif
                if (key_zero) begin
                    if (RelTarget <= 16'd1) begin
                        cnt_d   = 16'd0;
                        state_d = StIdle;
                    end else begin
                        cnt_d   = 16'd1;
                        state_d = StRelease;
                    end
                end
            end
            StRelease: begin
                if (key_zero) begin
                    if (cnt_inc >= RelTarget) begin
                        cnt_d   = 16'd0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    cnt_d   = 16'd0;
                    state_d = StHeld;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = StIdle;
            end
        endcase
    end

    // A new command may replace the pending one only in the cycle it is being consumed.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        dropped_d   = dropped_q;
        if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
        if (emit) begin
            if (!cmd_valid_q || cmd_ready) begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = key_code;
            end else begin
                dropped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pat_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 3'd0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            dropped_q   <= dropped_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign cmd_dropped = dropped_q;
    assign key_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_keypad_cmd_decoder.sv
// Bench for keypad_cmd_decoder: directed scenarios plus random key traffic, all checked every
// cycle against a run-length reference model of press qualification and the command hold slot.
module tb_keypad_cmd_decoder;

    localparam int Deb = 4;
    localparam int Rel = 4;
    localparam int Rep = 64;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int ExpHold = 4;
`else
    localparam int ExpHold = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] keypadPressed;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic        cmd_dropped;
    logic        key_busy;

    keypad_cmd_decoder #(
        .DEBOUNCE_CYCLES(Deb),
        .RELEASE_CYCLES (Rel),
        .REPEAT_CYCLES  (Rep)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .keypadPressed(keypadPressed),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .cmd_dropped  (cmd_dropped),
        .key_busy     (key_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [11:0] m_s1, m_s2, m_pat;
    bit          m_armed;
    int          m_run, m_zrun, m_rep;
    bit          m_pend, m_drop;
    logic [2:0]  m_code;

    int          tcount, start, first, pulses;
    logic [2:0]  first_code;

    logic [11:0] key_tab [5] = '{12'h002, 12'h080, 12'h008, 12'h020, 12'h200};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cmd_of(input logic [11:0] v, output logic [2:0] code);
        code = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (v === key_tab[i]) begin
                code = 3'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_pat = '0;
        m_armed = 1'b1; m_run = 0; m_zrun = 0; m_rep = 0;
        m_pend = 1'b0; m_drop = 1'b0; m_code = 3'd0;
    endtask

    task automatic model_step(input logic [11:0] raw, input logic rdy);
        logic [11:0] samp;
        logic [2:0]  scode;
        bit          svalid, emit_now;
        samp = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        emit_now = 1'b0;
        svalid = cmd_of(samp, scode);
        if (m_armed) begin
            // Need Deb identical valid samples in a row; a change wastes its own sample.
            if (m_run > 0 && svalid && samp === m_pat) m_run++;
            else if (m_run > 0) m_run = 0;
            else if (svalid) begin
                m_run = 1;
                m_pat = samp;
            end
            if (m_run == Deb) begin
                emit_now = 1'b1;
                m_armed = 1'b0; m_run = 0; m_zrun = 0; m_rep = 0;
            end
        end else if (samp === 12'h000) begin
            m_zrun++;
            m_rep = 0;
            if (m_zrun == Rel) begin
                m_armed = 1'b1;
                m_zrun = 0;
            end
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (m_zrun == 0 && svalid && samp === m_pat) begin
                m_rep++;
                if (m_rep == Rep) begin
                    emit_now = 1'b1;
                    m_rep = 0;
                end
            end else begin
                m_rep = 0;
            end
`endif
            m_zrun = 0;
        end
        if (emit_now) begin
            if (!m_pend || rdy) begin
                m_pend = 1'b1;
                m_code = scode;
            end else begin
                m_drop = 1'b1;
            end
        end else if (m_pend && rdy) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic tick(input logic [11:0] raw, input logic rdy);
        keypadPressed = raw;
        cmd_ready = rdy;
        @(posedge clk);
        model_step(raw, rdy);
        tcount++;
        #1;
        check_eq("known", {31'd0, $isunknown({cmd_valid, cmd_code, cmd_dropped, key_busy})}, 0);
        check_eq("valid", {31'd0, cmd_valid}, {31'd0, m_pend});
        check_eq("code", {29'd0, cmd_code}, {29'd0, m_code});
        check_eq("dropped", {31'd0, cmd_dropped}, {31'd0, m_drop});
        check_eq("busy", {31'd0, key_busy}, {31'd0, (!m_armed || m_run > 0)});
        if (cmd_valid === 1'b1) begin
            pulses++;
            if (first < 0) begin
                first = tcount - start;
                first_code = cmd_code;
            end
        end
    endtask

    task automatic hold(input logic [11:0] raw, input int n, input logic rdy);
        for (int i = 0; i < n; i++) tick(raw, rdy);
    endtask

    task automatic phase_start();
        start = tcount;
        first = -1;
        pulses = 0;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_valid", {31'd0, cmd_valid}, 0);
        check_eq("rst_code", {29'd0, cmd_code}, 0);
        check_eq("rst_dropped", {31'd0, cmd_dropped}, 0);
        check_eq("rst_busy", {31'd0, key_busy}, 0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    logic [2:0] exp_code [5] = '{3'd2, 3'd1, 3'd3, 3'd0, 3'd4};
    logic [11:0] press_tab [5] = '{12'h008, 12'h080, 12'h020, 12'h002, 12'h200};
    logic [11:0] rnd_tab [10] = '{12'h000, 12'h002, 12'h008, 12'h020, 12'h080,
                                  12'h200, 12'h028, 12'h010, 12'h001, 12'h800};

    initial begin
        rst_n = 1'b0;
        keypadPressed = '0;
        cmd_ready = 1'b0;
        tcount = 0;
        model_reset();
        phase_start();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        check_eq("init_valid", {31'd0, cmd_valid}, 0);
        check_eq("init_dropped", {31'd0, cmd_dropped}, 0);
        check_eq("init_busy", {31'd0, key_busy}, 0);

        phase_start();
        hold(12'h000, 20, 1'b1);
        check_eq("idle_pulses", pulses, 0);

        for (int k = 0; k < 5; k++) begin
            phase_start();
            hold(press_tab[k], 5, 1'b1);
            hold(12'h000, 10, 1'b1);
            check_eq("press_latency", first, 6);
            check_eq("press_pulses", pulses, 1);
            check_eq("press_code", {29'd0, first_code}, {29'd0, exp_code[k]});
        end

        phase_start();
        hold(12'h008, 2, 1'b1);
        hold(12'h000, 1, 1'b1);
        hold(12'h008, 2, 1'b1);
        hold(12'h000, 10, 1'b1);
        check_eq("bounce_pulses", pulses, 0);
        phase_start();
        hold(12'h028, 10, 1'b1);
        hold(12'h000, 10, 1'b1);
        hold(12'h010, 10, 1'b1);
        hold(12'h000, 10, 1'b1);
        hold(12'hxxx, 10, 1'b1);
        hold(12'h000, 10, 1'b1);
        check_eq("invalid_pulses", pulses, 0);

        hold(12'h020, 5, 1'b0);
        hold(12'h000, 10, 1'b0);
        hold(12'h080, 6, 1'b0);
        hold(12'h000, 10, 1'b0);
        check_eq("bp_valid", {31'd0, cmd_valid}, 1);
        check_eq("bp_code", {29'd0, cmd_code}, 3);
        check_eq("bp_dropped", {31'd0, cmd_dropped}, 1);
        tick(12'h000, 1'b1);
        check_eq("bp_cleared", {31'd0, cmd_valid}, 0);

        phase_start();
        hold(12'h002, 200, 1'b1);
        hold(12'h000, 2, 1'b1);
        hold(12'h002, 10, 1'b1);
        hold(12'h000, 10, 1'b1);
        check_eq("hold_pulses", pulses, ExpHold);

        // dropped is still set from the backpressure case, so the reset check is meaningful
        hold(12'h008, 2, 1'b1);
        async_reset();
        phase_start();
        hold(12'h008, 10, 1'b1);
        hold(12'h000, 10, 1'b1);
        check_eq("rst_requal_latency", first, 6);
        check_eq("rst_requal_pulses", pulses, 1);

        for (int s = 0; s < 300; s++) begin
            logic [11:0] pat;
            int len;
            logic rdy_mode;
            pat = rnd_tab[$urandom_range(0, 9)];
            len = $urandom_range(1, 12);
            rdy_mode = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) async_reset();
            for (int i = 0; i < len; i++) begin
                tick(pat, rdy_mode ? 1'b1 : 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
